// File: rtl/tpu_modaccum_pkg.sv
// rtl/tpu_modaccum_pkg.sv - shared types, widths and correction-LUT helper for the modular accumulator feeder
package tpu_modaccum_pkg;

  // Sequencer states: accumulate, two truncate/correct flush pairs, then hold result.
  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FL_T1,
    FL_C1,
    FL_T2,
    FL_C2,
    DONE
  } state_t;

  localparam int ACC_W = 21;
  localparam int LOW_W = 18;

  // (k * 2^18) mod m: weight of the truncated high bits folded back as a residue.
  // Only ever evaluated with constant arguments, so it elaborates to a constant table.
  function automatic logic [LOW_W-1:0] trunc_lut(input int k, input int m);
    int r;
    r = (k << LOW_W) % m;
    return LOW_W'(r);
  endfunction

endpackage

// File: rtl/modaccum_ctrl21.sv
// rtl/modaccum_ctrl21.sv - sequencer/feeder for the 21-bit modular accumulator
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   prod_in/prod_valid/prod_last     18-bit residue product stream (input)
//   prod_ready                       product accepted when valid && ready
//   acc_mod_result, acc_trunc_adr    accumulator state / truncated high bits
//   acc_in_a, acc_trunc_ena          accumulator addend and truncate strobe
//   acc_load_ena                     clears the accumulator on the next edge
//   res_data/res_valid/res_ready     final congruent sum (output stream)
//   busy                             sequencer not idle
module modaccum_ctrl21
  import tpu_modaccum_pkg::*;
#(
  parameter int MOD_M        = 262139,
  parameter int TRUNC_PERIOD = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [17:0] prod_in,
  input  logic        prod_valid,
  input  logic        prod_last,
  output logic        prod_ready,
  input  logic [20:0] acc_mod_result,
  input  logic [2:0]  acc_trunc_adr,
  output logic [19:0] acc_in_a,
  output logic        acc_trunc_ena,
  output logic        acc_load_ena,
  output logic [18:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy
);

  // More than 5 accumulate cycles between truncations could overflow 21 bits.
  if (TRUNC_PERIOD < 1 || TRUNC_PERIOD > 5) begin : g_bad_period
    $error("modaccum_ctrl21: TRUNC_PERIOD must be in 1..5");
  end

  localparam logic [2:0] CNT_LAST = 3'(TRUNC_PERIOD - 1);

  state_t           state, state_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic [LOW_W-1:0] corr_q;
  logic [LOW_W-1:0] lut [8];
  logic             accepted;
  logic             unused_hi;

  for (genvar g = 0; g < 8; g++) begin : g_lut
    assign lut[g] = trunc_lut(g, MOD_M);
  end

  // Only ACCUM raises prod_ready, so acceptance is decoded from state directly.
  assign accepted = prod_valid && (state == ACCUM);

  // trunc_adr is 0 whenever no truncation happened, so corr_q is 0 then and the
  // correction lands exactly one cycle after its truncate pulse.
  assign acc_in_a = {2'b00, (accepted ? prod_in : 18'd0)} + {2'b00, corr_q};

  // Upper two bits are 0 by bound after the double flush.
  assign res_data  = acc_mod_result[18:0];
  assign unused_hi = ^acc_mod_result[20:19];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      corr_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      corr_q <= lut[acc_trunc_adr];
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    prod_ready    = 1'b0;
    acc_trunc_ena = 1'b0;
    acc_load_ena  = 1'b0;
    res_valid     = 1'b0;
    case (state)
      IDLE: begin
        // The accumulator has no reset; holding load keeps it at 0.
        acc_load_ena = 1'b1;
        cnt_nxt      = 3'd0;
        if (prod_valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        prod_ready    = 1'b1;
        acc_trunc_ena = (cnt == CNT_LAST);
        cnt_nxt       = (cnt == CNT_LAST) ? 3'd0 : cnt + 3'd1;
        if (prod_valid && prod_last) begin
          state_nxt = FL_T1;
          cnt_nxt   = 3'd0;
        end
      end
      FL_T1: begin
        acc_trunc_ena = 1'b1;
        state_nxt     = FL_C1;
      end
      FL_C1: state_nxt = FL_T2;
      FL_T2: begin
        acc_trunc_ena = 1'b1;
        state_nxt     = FL_C2;
      end
      FL_C2: state_nxt = DONE;
      DONE: begin
        res_valid    = 1'b1;
        // Clearing overlaps the handshake so back-to-back sums lose one cycle only.
        acc_load_ena = res_ready;
        if (res_ready) begin
          state_nxt = ACCUM;
          cnt_nxt   = 3'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_modaccum_ctrl21.sv
// tb/tb_modaccum_ctrl21.sv - self-checking bench for modaccum_ctrl21 with a behavioural accumulator
module tb_modaccum_ctrl21;

  localparam int M = 262139;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] prod_in = '0;
  logic        prod_valid = 1'b0;
  logic        prod_last = 1'b0;
  logic        res_ready = 1'b0;
  logic        prod_ready;
  logic [20:0] acc_mod_result;
  logic [2:0]  acc_trunc_adr;
  logic [19:0] acc_in_a;
  logic        acc_trunc_ena;
  logic        acc_load_ena;
  logic [18:0] res_data;
  logic        res_valid;
  logic        busy;

  modaccum_ctrl21 #(.MOD_M(M), .TRUNC_PERIOD(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_last(prod_last), .prod_ready(prod_ready),
    .acc_mod_result(acc_mod_result), .acc_trunc_adr(acc_trunc_adr),
    .acc_in_a(acc_in_a), .acc_trunc_ena(acc_trunc_ena), .acc_load_ena(acc_load_ena),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Accumulator model: truncate drops bits 20:18 (reported on trunc_adr) while adding in_a.
  logic [20:0] accum = '0;
  int          ovf = 0;
  assign acc_mod_result = accum;
  assign acc_trunc_adr  = acc_trunc_ena ? accum[20:18] : 3'd0;

  always @(posedge clk) begin
    logic [21:0] s;
    if (acc_load_ena) accum <= '0;
    else begin
      s = (acc_trunc_ena ? {4'b0, accum[17:0]} : {1'b0, accum}) + {2'b0, acc_in_a};
      if (s[21]) ovf++;
      accum <= s[20:0];
    end
  end

  int     errors = 0, checks = 0;
  int     cyc = 0, last_acc_cyc = -100, prev_adr = 0;
  bit     prev_rv = 0, acc_now = 0;
  longint sum = 0;
  longint exp_q[$];
  longint res_log[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, sample after settling, run scoreboard and correction checks.
  task automatic cycle(input logic [17:0] p, input bit v, input bit l, input bit rr);
    longint e;
    @(negedge clk);
    prod_in = p; prod_valid = v; prod_last = l; res_ready = rr;
    #1;
    cyc++;
    acc_now = v && prod_ready;
    chk("in_a", acc_in_a, (acc_now ? longint'(p) : 0) + ((longint'(prev_adr) * 262144) % M));
    prev_adr = acc_trunc_adr;
    if (acc_now) begin
      sum = (sum + p) % M;
      if (l) begin
        exp_q.push_back(sum);
        sum = 0;
        last_acc_cyc = cyc;
      end
    end
    if (res_valid && !prev_rv) chk("latency", cyc - last_acc_cyc, 5);
    prev_rv = res_valid;
    if (res_valid && rr) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got %0d expected none", res_data);
      end else begin
        e = exp_q.pop_front();
        chk("res_mod", res_data % M, e);
        chk("res_bound", (res_data < 262144 + M) ? 1 : 0, 1);
        res_log.push_back(res_data);
      end
    end
  endtask

  task automatic send(input logic [17:0] p, input bit l, input int gap);
    int n = 0;
    do begin
      if (gap > 0 && $urandom_range(99) < gap) cycle(~p, 1'b0, l, 1'b1);
      else cycle(p, 1'b1, l, 1'b1);
      n++;
    end while (!acc_now && n < 50);
    if (!acc_now) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_results(input int target);
    int n = 0;
    while (res_log.size() < target && n < 50) begin
      cycle(18'd0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("result_count", res_log.size(), target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_prod_ready"}, prod_ready, 0);
    chk({tag, "_trunc_ena"}, acc_trunc_ena, 0);
    chk({tag, "_load_ena"}, acc_load_ena, 1);
    chk({tag, "_in_a"}, acc_in_a, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [17:0] prod;
    bit v, l, rr;
    bit e_ready, e_trunc, e_load, e_rv, e_busy;
    int e_data;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Single product 7 through flush and handshake, then idle ACCUM cycles showing the trunc period.
    tbl[0]  = '{18'd7, 1, 1, 0,  0, 0, 1, 0, 0, -1};
    tbl[1]  = '{18'd7, 1, 1, 0,  1, 0, 0, 0, 1, -1};
    tbl[2]  = '{18'd0, 0, 0, 0,  0, 1, 0, 0, 1, -1};
    tbl[3]  = '{18'd0, 0, 0, 0,  0, 0, 0, 0, 1, -1};
    tbl[4]  = '{18'd0, 0, 0, 0,  0, 1, 0, 0, 1, -1};
    tbl[5]  = '{18'd0, 0, 0, 0,  0, 0, 0, 0, 1, -1};
    tbl[6]  = '{18'd0, 0, 0, 0,  0, 0, 0, 1, 1, 7};
    tbl[7]  = '{18'd0, 0, 0, 1,  0, 0, 1, 1, 1, 7};
    tbl[8]  = '{18'd0, 0, 0, 1,  1, 0, 0, 0, 1, -1};
    tbl[9]  = '{18'd0, 0, 1, 1,  1, 0, 0, 0, 1, -1};
    tbl[10] = '{18'd0, 0, 0, 1,  1, 0, 0, 0, 1, -1};
    tbl[11] = '{18'd0, 0, 0, 1,  1, 1, 0, 0, 1, -1};
    tbl[12] = '{18'd0, 0, 0, 1,  1, 0, 0, 0, 1, -1};

    #1;
    check_reset_outputs("reset");
    repeat (2) cycle(18'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].prod, tbl[i].v, tbl[i].l, tbl[i].rr);
      chk($sformatf("t%0d_prod_ready", i), prod_ready, tbl[i].e_ready);
      chk($sformatf("t%0d_trunc_ena", i), acc_trunc_ena, tbl[i].e_trunc);
      chk($sformatf("t%0d_load_ena", i), acc_load_ena, tbl[i].e_load);
      chk($sformatf("t%0d_res_valid", i), res_valid, tbl[i].e_rv);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_data >= 0) chk($sformatf("t%0d_res_data", i), res_data, tbl[i].e_data);
    end

    // 16 x (M-1), continuous; trunc counter sits at 1 after the table.
    for (int i = 0; i < 16; i++) begin
      send(18'(M - 1), i == 15, 0);
      chk($sformatf("period_trunc_%0d", i), acc_trunc_ena, (((i + 1) % 4) == 3) ? 1 : 0);
    end
    wait_results(2);
    chk("max_sum_mod", res_log[1] % M, 262123);
    chk("max_sum_bound", (res_log[1] < 524283) ? 1 : 0, 1);

    // 40 random residues with 30% gaps (gap beats carry a stray prod_last).
    for (int i = 0; i < 40; i++) send(18'($urandom_range(M - 1)), i == 39, 30);
    wait_results(3);

    // Result held while downstream stalls.
    send(18'd100, 1'b0, 0);
    send(18'd200, 1'b1, 0);
    begin
      int n = 0;
      do begin cycle(18'd0, 1'b0, 1'b0, 1'b0); n++; end while (!res_valid && n < 20);
    end
    chk("stall_reached_done", res_valid, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(18'd0, 1'b0, 1'b0, 1'b0);
      chk("stall_data", res_data, 300);
      chk("stall_prod_ready", prod_ready, 0);
      chk("stall_load_ena", acc_load_ena, 0);
    end
    cycle(18'd0, 1'b0, 1'b0, 1'b1);
    chk("release_load_ena", acc_load_ena, 1);
    cycle(18'd0, 1'b0, 1'b0, 1'b1);
    chk("release_prod_ready", prod_ready, 1);
    chk("release_accum_zero", acc_mod_result, 0);
    chk("stall_result_count", res_log.size(), 4);

    // Back-to-back dot products.
    send(18'd1, 1'b0, 0); send(18'd2, 1'b0, 0); send(18'd3, 1'b1, 0);
    send(18'd10, 1'b0, 0); send(18'd20, 1'b1, 0);
    wait_results(6);
    chk("b2b_first", res_log[4], 6);
    chk("b2b_second", res_log[5], 30);

    // Reset in the middle of accumulation.
    send(18'd11, 1'b0, 0);
    send(18'd22, 1'b0, 0);
    cycle(18'd33, 1'b1, 1'b0, 1'b1);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sum = 0; prev_adr = 0; prev_rv = 0;
    repeat (2) cycle(18'd0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    send(18'd4, 1'b0, 0);
    send(18'd5, 1'b1, 0);
    wait_results(7);
    chk("post_reset_sum", res_log[6], 9);

    chk("acc_overflow", ovf, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modaccum_ctrl21.md
Name: modaccum_ctrl21

Overview:
- Upstream sequencer and feeder for the 21-bit modular accumulator stage (adder_accum21) at the end of the TPU modmultaccum path.
- Accepts a stream of 18-bit reduced residue products with a valid/ready handshake.
- Drives the accumulator's in_a, trunc_ena and load_ena, folding truncated high bits back in through a (k·2^18 mod M) correction LUT.
- Flushes after the last product and presents the final congruent sum downstream with a valid/ready handshake.

Parameters:
- MOD_M, 262139, modulus (< 2^18); all products are < MOD_M.
- TRUNC_PERIOD, 4, ACCUM cycles between trunc_ena pulses; legal range 1..5, enforced by elaboration assertion. The range keeps the accumulator below 2^21.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- prod_in  in  18  residue product
- prod_valid  in  1  product valid
- prod_last  in  1  last product of the current dot product
- prod_ready  out  1  product accepted when valid&&ready
- acc_mod_result  in  21  accumulator mod_result
- acc_trunc_adr  in  3  accumulator trunc_adr
- acc_in_a  out  20  to accumulator in_a
- acc_trunc_ena  out  1  to accumulator trunc_ena
- acc_load_ena  out  1  to accumulator load_ena (clears accum next edge)
- res_data  out  19  final sum, congruent mod MOD_M, < 2^18+MOD_M
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- busy  out  1  state != IDLE

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous and active-low. All flops clear on reset: state=IDLE, cnt=0, corr_q=0.
- Reset values: prod_ready=0, acc_trunc_ena=0, acc_load_ena=1, acc_in_a=0, res_valid=0, busy=0.
- Correction pipe, every cycle:
  - corr_q <= LUT[acc_trunc_adr], where LUT[k] = (k·2^18) mod MOD_M is a constant.
  - acc_trunc_adr is 0 whenever trunc_ena=0, so corr_q=0 then.
  - acc_in_a = zero-extend(accepted ? prod_in : 0) + corr_q. The sum is < 2^19, so it never overflows 20 bits.
  - Net effect: a correction lands exactly one cycle after its trunc pulse.
- States:
  - IDLE: load_ena=1, prod_ready=0. The accumulator (which has no reset) is held at 0. Go to ACCUM when prod_valid=1; that product is not consumed.
  - ACCUM: prod_ready=1, load_ena=0.
    - cnt increments every ACCUM cycle, whether or not a product is accepted, wrapping at TRUNC_PERIOD-1.
    - acc_trunc_ena=1 when cnt==TRUNC_PERIOD-1.
    - An accepted beat with prod_last=1 goes to FL_T1 and clears cnt.
  - FL_T1: trunc_ena=1, prod_ready=0; in_a=corr_q.
  - FL_C1: trunc_ena=0; in_a=corr_q.
  - FL_T2: trunc_ena=1.
  - FL_C2: trunc_ena=0.
  - Flush states are one cycle each; FL_C2 goes to DONE.
- DONE:
  - res_valid=1; res_data=acc_mod_result[18:0]. Bits 20:19 are 0 by bound.
  - in_a=0 and trunc_ena=0, so accum and res_data hold stable.
  - acc_load_ena=res_ready (Mealy).
  - On res_ready=1, go to ACCUM with cnt=0. The accumulator is 0 on the next cycle and corr_q=0.
- Latency: last product accepted at cycle t → res_valid asserted at t+5.
- Back-to-back dot products cost 1 dead (clear) cycle, overlapping the DONE handshake.
- Boundary rules:
  - prod_last on the same beat as a trunc pulse is legal; the FL_T1 correction absorbs it.
  - prod_valid=0 during ACCUM still advances cnt and injects corr_q.
  - A dot product of length 1 is legal.
  - prod_last with prod_valid=0 is ignored.
  - Reset mid-operation: immediate return to IDLE. An in-flight product is dropped and res_valid drops asynchronously.
  - res_ready held low indefinitely: hold DONE and assert no prod_ready.

Decomposition:
- Package tpu_modaccum_pkg contains:
  - state_t enum (IDLE, ACCUM, FL_T1, FL_C1, FL_T2, FL_C2, DONE)
  - ACC_W=21, LOW_W=18 constants
  - function trunc_lut(k, m) returning (k<<18)%m for constant LUT elaboration
- No sub-module: the LUT is an 8-entry constant array inside the block.
- Integration test wrapper instantiates modaccum_ctrl21 plus adder_accum21.

Test Plan:
- Integration wrapper, MOD_M=262139 (LUT[k]=5k): single product 7 with prod_last → res_data=7 at t+5, load_ena pulses with res_ready=1.
- 16 products of 262138 (=M-1), continuous valid → res_data mod 262139 == 262123 and res_data < 524283. Verify trunc_ena is high every 4th ACCUM cycle and acc_in_a includes 5·trunc_adr exactly one cycle later.
- 40 random residues with random prod_valid gaps (30%) → res_data ≡ Σ mod M. Accumulator never exceeds 2^21-1 (assert on acc_mod_result carry).
- res_ready low for 6 cycles in DONE → res_data stable, prod_ready=0, load_ena=0. Then res_ready=1 → ACCUM next cycle with accumulator=0.
- Two back-to-back dot products ({1,2,3}, {10,20}) → res_data 6 then 30, no cross-contamination.
- reset_n low mid-ACCUM → outputs at reset values immediately. A following dot product {4,5} → 9.
